// File: rtl/col_parity_engine.sv
// rtl/col_parity_engine.sv - column-parity (theta) engine streaming DEPTH slices through external slice memory
module col_parity_engine #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [24:0]   rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [24:0]   wr_data,
    input  logic          wr_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE_RD, S_PRE_CAP, S_RD, S_CAP, S_WR, S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state_q;
    logic          busy_q, done_q, rd_en_q, wr_en_q, mode_q;
    logic [AW-1:0] rd_addr_q, wr_addr_q, z_q;
    logic [24:0]   wr_data_q;
    logic [4:0]    prev_par_q, cur_par_q;

    logic [4:0]    cur_par_d;
    logic [4:0]    mix_d;
    logic [24:0]   result_d;

    function automatic logic [4:0] col_par(input logic [24:0] s);
        logic [4:0] c;
        c = '0;
        for (int y = 0; y < 5; y++) c = c ^ s[5*y +: 5];
        return c;
    endfunction

    // mix_d[x] = C[(x+4)%5] of this slice ^ C[(x+1)%5] of the previous slice
    always_comb begin
        cur_par_d = col_par(rd_data);
        mix_d     = {cur_par_d[3:0], cur_par_d[4]} ^ {prev_par_q[0], prev_par_q[4:1]};
        result_d  = mode_q ? {20'b0, cur_par_d} : (rd_data ^ {5{mix_d}});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            mode_q     <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            z_q        <= '0;
            wr_data_q  <= '0;
            prev_par_q <= '0;
            cur_par_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= LAST;
                        state_q   <= S_PRE_RD;
                    end
                end
                S_PRE_RD: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_PRE_CAP;
                end
                S_PRE_CAP: begin
                    // slice DEPTH-1 parity seeds the z-1 term of slice 0
                    prev_par_q <= cur_par_d;
                    z_q        <= '0;
                    rd_en_q    <= 1'b1;
                    rd_addr_q  <= '0;
                    state_q    <= S_RD;
                end
                S_RD: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= z_q;
                    wr_data_q <= result_d;
                    cur_par_q <= cur_par_d;
                    state_q   <= S_WR;
                end
                S_WR: begin
                    if (wr_ready) begin
                        wr_en_q    <= 1'b0;
                        prev_par_q <= cur_par_q;
                        if (z_q == LAST) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            z_q       <= z_q + 1'b1;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= z_q + 1'b1;
                            state_q   <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_col_parity_engine.sv
// tb/tb_col_parity_engine.sv - self-checking bench for col_parity_engine at DEPTH 64 and DEPTH 8
module tb_col_parity_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, mode, wr_ready, sel, load;
    logic start64, start8;
    assign start64 = start & ~sel;
    assign start8  = start & sel;

    logic        b64, d64, re64, we64;
    logic [5:0]  ra64, wa64;
    logic [24:0] rd64, wd64;
    logic        b8, d8, re8, we8;
    logic [2:0]  ra8, wa8;
    logic [24:0] rd8, wd8;

    col_parity_engine #(.DEPTH(64), .AW(6)) u64 (
        .clk(clk), .rst(rst), .start(start64), .mode(mode), .busy(b64), .done(d64),
        .rd_en(re64), .rd_addr(ra64), .rd_data(rd64),
        .wr_en(we64), .wr_addr(wa64), .wr_data(wd64), .wr_ready(wr_ready)
    );

    col_parity_engine #(.DEPTH(8), .AW(3)) u8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode), .busy(b8), .done(d8),
        .rd_en(re8), .rd_addr(ra8), .rd_data(rd8),
        .wr_en(we8), .wr_addr(wa8), .wr_data(wd8), .wr_ready(wr_ready)
    );

    logic        cur_busy, cur_done, cur_rd_en, cur_wr_en;
    logic [6:0]  cur_rd_addr, cur_wr_addr;
    logic [24:0] cur_wr_data;
    assign cur_busy    = sel ? b8 : b64;
    assign cur_done    = sel ? d8 : d64;
    assign cur_rd_en   = sel ? re8 : re64;
    assign cur_wr_en   = sel ? we8 : we64;
    assign cur_rd_addr = sel ? {4'b0, ra8} : {1'b0, ra64};
    assign cur_wr_addr = sel ? {4'b0, wa8} : {1'b0, wa64};
    assign cur_wr_data = sel ? wd8 : wd64;

    logic [24:0] img [64];
    logic [24:0] mem64 [64];
    logic [24:0] mem8 [8];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 64; i++) mem64[i] <= img[i];
            for (int i = 0; i < 8; i++) mem8[i] <= img[i];
        end else begin
            if (re64) rd64 <= mem64[ra64];
            if (we64 && wr_ready) mem64[wa64] <= wd64;
            if (re8) rd8 <= mem8[ra8];
            if (we8 && wr_ready) mem8[wa8] <= wd8;
        end
    end

    int          n_chk = 0;
    int          n_fail = 0;
    int          wq_addr [$];
    logic [24:0] wq_data [$];
    int          first_rd, dcyc;
    logic        busy_after;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Theta straight from the column definitions, on the pre-pass image
    function automatic logic [24:0] ref_slice(input int dep, input bit md, input int z);
        bit [4:0]    cc, cp;
        logic [24:0] r;
        int          zp;
        zp = (z + dep - 1) % dep;
        cc = '0;
        cp = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) begin
                cc[x] = cc[x] ^ img[z][x + 5*y];
                cp[x] = cp[x] ^ img[zp][x + 5*y];
            end
        if (md) return {20'b0, cc};
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x + 5*y] = img[z][x + 5*y] ^ cc[(x + 4) % 5] ^ cp[(x + 1) % 5];
        return r;
    endfunction

    task automatic load_mem();
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic run_pass(input bit s, input bit md, input int stall_at, input int stall_len,
                            input bit poke);
        int          dep, left;
        logic [24:0] held;
        dep = s ? 8 : 64;
        sel = s;
        mode = md;
        wr_ready = 1'b1;
        wq_addr.delete();
        wq_data.delete();
        first_rd = -1;
        dcyc = -1;
        left = stall_len;
        held = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 1; cyc <= 4*dep + stall_len + 20; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (poke && cyc == 20) begin mode = ~md; start = 1'b1; end
            if (poke && cyc == 21) start = 1'b0;
            if (cur_rd_en && first_rd < 0) first_rd = int'(cur_rd_addr);
            wr_ready = 1'b1;
            if (cur_wr_en && int'(cur_wr_addr) == stall_at && left > 0) begin
                if (left == stall_len) held = cur_wr_data;
                chk($sformatf("stall_addr c%0d", cyc), cur_wr_addr, stall_at);
                chk($sformatf("stall_data c%0d", cyc), cur_wr_data, held);
                chk($sformatf("stall_no_rd c%0d", cyc), cur_rd_en, 1'b0);
                wr_ready = 1'b0;
                left--;
            end else if (cur_wr_en && int'(cur_wr_addr) == stall_at && stall_len > 0) begin
                chk("stall_accept_data", cur_wr_data, held);
            end
            if (cur_wr_en && wr_ready) begin
                wq_addr.push_back(int'(cur_wr_addr));
                wq_data.push_back(cur_wr_data);
            end
            if (cur_done) begin
                dcyc = cyc;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        busy_after = cur_busy | cur_done;
    endtask

    task automatic verify(input string tag, input bit s, input bit md, input int exp_done);
        int dep;
        dep = s ? 8 : 64;
        chk({tag, " first_rd_addr"}, first_rd, dep - 1);
        chk({tag, " done_cycle"}, dcyc, exp_done);
        chk({tag, " busy_after_done"}, busy_after, 1'b0);
        chk({tag, " n_writes"}, wq_addr.size(), dep);
        for (int i = 0; i < dep && i < wq_addr.size(); i++) begin
            chk($sformatf("%s wr_addr[%0d]", tag, i), wq_addr[i], i);
            chk($sformatf("%s wr_data[%0d]", tag, i), wq_data[i], ref_slice(dep, md, i));
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, cur_busy, 1'b0);
        chk({tag, " done"}, cur_done, 1'b0);
        chk({tag, " rd_en"}, cur_rd_en, 1'b0);
        chk({tag, " wr_en"}, cur_wr_en, 1'b0);
        chk({tag, " rd_addr"}, cur_rd_addr, 0);
        chk({tag, " wr_addr"}, cur_wr_addr, 0);
        chk({tag, " wr_data"}, cur_wr_data, 0);
    endtask

    typedef struct {
        bit          s;
        bit          md;
        int          idx;
        logic [24:0] val;
        int          slice;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int dep, sa, sl, cnt;
        bit s, md, found;
        tbl[0]  = '{1'b0, 1'b0, 0,  25'h0,  17, 25'h0};
        tbl[1]  = '{1'b0, 1'b0, 0,  25'h1,  0,  25'h0210843};
        tbl[2]  = '{1'b0, 1'b0, 0,  25'h1,  1,  25'h1084210};
        tbl[3]  = '{1'b0, 1'b0, 0,  25'h1,  2,  25'h0};
        tbl[4]  = '{1'b0, 1'b0, 63, 25'h1,  0,  25'h1084210};
        tbl[5]  = '{1'b0, 1'b0, 63, 25'h1,  63, 25'h0210843};
        tbl[6]  = '{1'b0, 1'b1, 5,  25'h21, 5,  25'h0};
        tbl[7]  = '{1'b0, 1'b1, 6,  25'h1F, 6,  25'h1F};
        tbl[8]  = '{1'b1, 1'b0, 0,  25'h0,  5,  25'h0};
        tbl[9]  = '{1'b1, 1'b0, 0,  25'h1,  0,  25'h0210843};
        tbl[10] = '{1'b1, 1'b0, 0,  25'h1,  1,  25'h1084210};
        tbl[11] = '{1'b1, 1'b0, 7,  25'h1,  0,  25'h1084210};
        tbl[12] = '{1'b1, 1'b0, 7,  25'h1,  7,  25'h0210843};

        rst = 1'b0; start = 1'b0; mode = 1'b0; wr_ready = 1'b1; sel = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b0; chk_idle("reset d64");
        sel = 1'b1; chk_idle("reset d8");
        rst = 1'b1;

        for (int t = 0; t < 13; t++) begin
            dep = tbl[t].s ? 8 : 64;
            for (int i = 0; i < 64; i++) img[i] = '0;
            img[tbl[t].idx] = tbl[t].val;
            load_mem();
            run_pass(tbl[t].s, tbl[t].md, -1, 0, 1'b0);
            verify($sformatf("vec%0d", t), tbl[t].s, tbl[t].md, 3*dep + 3);
            if (wq_data.size() > tbl[t].slice)
                chk($sformatf("vec%0d slice%0d", t, tbl[t].slice), wq_data[tbl[t].slice], tbl[t].exp);
            else
                chk($sformatf("vec%0d slice_missing", t), wq_data.size(), tbl[t].slice + 1);
        end

        // Backpressure at slice 10, with a stray start and mode toggle mid-pass
        for (int i = 0; i < 64; i++) img[i] = 25'($urandom);
        load_mem();
        run_pass(1'b0, 1'b0, 10, 5, 1'b1);
        verify("stall5", 1'b0, 1'b0, 3*64 + 3 + 5);

        // Reset in the middle of the slice 30 write
        sel = 1'b0; mode = 1'b0;
        load_mem();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (cur_wr_en && cur_wr_addr == 7'd30) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("reset_reach_slice30", found, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_idle("midpass_reset");
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (cur_wr_en || cur_busy) cnt++;
        end
        chk("post_reset_quiet", cnt, 0);
        load_mem();
        run_pass(1'b0, 1'b1, -1, 0, 1'b0);
        verify("after_reset", 1'b0, 1'b1, 3*64 + 3);

        for (int r = 0; r < 6; r++) begin
            s   = 1'($urandom_range(0, 1));
            md  = 1'($urandom_range(0, 1));
            dep = s ? 8 : 64;
            sa  = $urandom_range(0, dep - 1);
            sl  = $urandom_range(0, 3);
            for (int i = 0; i < 64; i++) img[i] = 25'($urandom);
            load_mem();
            run_pass(s, md, sa, sl, 1'(r % 2));
            verify($sformatf("rand%0d", r), s, md, 3*dep + 3 + sl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
